// File: rtl/collision_ci_multi.sv
// Custom-instruction front end for a multi-engine hash collision search.
// Keeps the 16-word message buffer, hands out candidate counters to idle engines, and records the first matching counter.
module collision_ci_multi #(
   parameter int NUM_ENG    = 4,
   parameter int MATCH_BITS = 24
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clk_en,
   input  logic                          start,
   input  logic [31:0]                   dataa,
   input  logic [31:0]                   datab,
   input  logic [2:0]                    n,
   output logic                          done,
   output logic [31:0]                   result,
   output logic [511:0]                  eng_msg,
   output logic [NUM_ENG-1:0]            eng_start,
   output logic [32*NUM_ENG-1:0]         eng_ctr,
   input  logic [NUM_ENG-1:0]            eng_done,
   input  logic [MATCH_BITS*NUM_ENG-1:0] eng_digest
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEARCH    = 3'd1,
      ST_DRAIN     = 3'd2,
      ST_FOUND     = 3'd3,
      ST_EXHAUSTED = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [31:0]            msg_q [16];
   logic [31:0]            msg_d [16];
   logic [3:0]             wp_q, wp_d;
   logic [MATCH_BITS-1:0]  target_q, target_d;
   logic [31:0]            next_q, next_d;
   logic [31:0]            found_q, found_d;
   logic [31:0]            dcount_q, dcount_d;
   logic                   wrap_q, wrap_d;
   logic                   pend_q, pend_d;
   logic [NUM_ENG-1:0]     busy_q, busy_d;
   logic [NUM_ENG-1:0]     start_q, start_d;
   logic [32*NUM_ENG-1:0]  ctr_q, ctr_d;
   logic                   done_q, done_d;
   logic [31:0]            result_q, result_d;

   logic                   accept_s;
   logic                   abort_s;
   logic                   hit_s;
   logic                   launched_s;
   logic [NUM_ENG-1:0]     valid_s;
   logic [31:0]            pop_s;
   logic [32:0]            sum_s;

   // Instruction decode, engine dispatch/completion and next-state logic.
   always_comb begin
      state_d    = state_q;
      msg_d      = msg_q;
      wp_d       = wp_q;
      target_d   = target_q;
      next_d     = next_q;
      found_d    = found_q;
      dcount_d   = dcount_q;
      wrap_d     = wrap_q;
      pend_d     = pend_q;
      ctr_d      = ctr_q;
      result_d   = result_q;
      start_d    = '0;
      accept_s   = clk_en & start & ~done_q;
      done_d     = accept_s;
      abort_s    = 1'b0;
      hit_s      = 1'b0;
      launched_s = 1'b0;
      pop_s      = 32'd0;
      sum_s      = 33'd0;
      // A completion on an engine that is not busy is stale and ignored.
      valid_s    = eng_done & busy_q;
      busy_d     = busy_q & ~valid_s;

      if (accept_s) begin
         case (n)
            3'd0: begin
               if (state_q == ST_SEARCH || state_q == ST_DRAIN) begin
                  result_d = 32'hFFFF_FFFF;
               end else begin
                  msg_d[wp_q]        = dataa;
                  msg_d[wp_q + 4'd1] = datab;
                  wp_d               = wp_q + 4'd2;
                  result_d           = 32'd0;
               end
            end
            3'd1: begin
               if (busy_q != '0 || state_q == ST_SEARCH || state_q == ST_DRAIN) begin
                  result_d = 32'hFFFF_FFFF;
               end else begin
                  target_d = dataa[MATCH_BITS-1:0];
                  next_d   = datab;
                  found_d  = 32'd0;
                  dcount_d = 32'd0;
                  wrap_d   = 1'b0;
                  pend_d   = 1'b0;
                  state_d  = ST_SEARCH;
                  result_d = 32'd0;
               end
            end
            3'd2: result_d = found_q;
            3'd3: begin
               case (state_q)
                  ST_SEARCH, ST_DRAIN: result_d = 32'd0;
                  ST_FOUND:            result_d = 32'd1;
                  ST_IDLE:             result_d = 32'd2;
                  ST_EXHAUSTED:        result_d = 32'd3;
                  default:             result_d = 32'd2;
               endcase
            end
            3'd4: result_d = dcount_q;
            3'd5: begin
               if (state_q == ST_SEARCH) begin
                  state_d = ST_DRAIN;
                  abort_s = 1'b1;
               end else begin
                  state_d = state_q;
               end
               result_d = 32'd0;
            end
            3'd6: begin
               wp_d     = 4'd0;
               result_d = 32'd0;
            end
            3'd7: result_d = {16'(NUM_ENG), 16'(MATCH_BITS)};
            default: result_d = 32'd0;
         endcase
      end else begin
         result_d = result_q;
      end

      if (state_q == ST_SEARCH) begin
         for (int i = 0; i < NUM_ENG; i++) begin
            pop_s = pop_s + 32'(valid_s[i]);
         end
         sum_s    = {1'b0, dcount_q} + {1'b0, pop_s};
         dcount_d = sum_s[32] ? 32'hFFFF_FFFF : sum_s[31:0];
         // Scan downward so the lowest-index matching engine is the one recorded.
         for (int i = NUM_ENG - 1; i >= 0; i--) begin
            if (valid_s[i] && (eng_digest[i*MATCH_BITS +: MATCH_BITS] == target_q)) begin
               hit_s   = 1'b1;
               found_d = ctr_q[i*32 +: 32];
            end else begin
               hit_s   = hit_s;
            end
         end
         if (hit_s) begin
            state_d = ST_DRAIN;
            pend_d  = 1'b1;
         end else if (!abort_s && !wrap_q) begin
            for (int i = 0; i < NUM_ENG; i++) begin
               if (!launched_s && !busy_d[i]) begin
                  launched_s        = 1'b1;
                  start_d[i]        = 1'b1;
                  busy_d[i]         = 1'b1;
                  ctr_d[i*32 +: 32] = next_q;
                  next_d            = next_q + 32'd1;
                  wrap_d            = (next_q == 32'hFFFF_FFFF);
               end else begin
                  launched_s        = launched_s;
               end
            end
         end else if (!abort_s && busy_d == '0) begin
            state_d = ST_EXHAUSTED;
         end else begin
            state_d = state_d;
         end
      end else if (state_q == ST_DRAIN) begin
         if (busy_d == '0) begin
            state_d = pend_q ? ST_FOUND : ST_IDLE;
         end else begin
            state_d = state_q;
         end
      end else begin
         busy_d = busy_d;
      end
   end

   // State registers; reset abandons every job and clears the buffer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         for (int k = 0; k < 16; k++) begin
            msg_q[k] <= 32'd0;
         end
         wp_q     <= 4'd0;
         target_q <= '0;
         next_q   <= 32'd0;
         found_q  <= 32'd0;
         dcount_q <= 32'd0;
         wrap_q   <= 1'b0;
         pend_q   <= 1'b0;
         busy_q   <= '0;
         start_q  <= '0;
         ctr_q    <= '0;
         done_q   <= 1'b0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         for (int k = 0; k < 16; k++) begin
            msg_q[k] <= msg_d[k];
         end
         wp_q     <= wp_d;
         target_q <= target_d;
         next_q   <= next_d;
         found_q  <= found_d;
         dcount_q <= dcount_d;
         wrap_q   <= wrap_d;
         pend_q   <= pend_d;
         busy_q   <= busy_d;
         start_q  <= start_d;
         ctr_q    <= ctr_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   // Buffer word 0 sits in the most significant bits of the broadcast message.
   always_comb begin
      eng_msg = '0;
      for (int k = 0; k < 16; k++) begin
         eng_msg[511 - 32*k -: 32] = msg_q[k];
      end
   end

   assign done      = done_q;
   assign result    = result_q;
   assign eng_start = start_q;
   assign eng_ctr   = ctr_q;

endmodule
